y86_writeback: RTL and testbench

- Write-back stage of the SEQ Y86-64 processor; sits directly downstream of the memory stage.
- Consumes valE from execute, and valM, dmem_error and func_error from memory.
- Owns the 15-entry architectural register file; commits results at the clock edge and serves the combinational register reads used by decode.
- Maintains the sticky processor status (AOK/HLT/ADR/INS) and a retired-instruction counter.

---
 rtl/y86_writeback.sv | 132 +++++++++++++
 tb/tb_y86_writeback.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_writeback.sv
// SEQ Y86-64 write-back stage: architectural register file, sticky status and retire counter.
// Reads are combinational from committed state; commits happen on the rising clock edge.
module y86_writeback #(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(1023),
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_valid,
  input  logic [3:0]        i_icode,
  input  logic [3:0]        i_ra,
  input  logic [3:0]        i_rb,
  input  logic              i_cnd,
  input  logic [DATA_W-1:0] i_val_e,
  input  logic [DATA_W-1:0] i_val_m,
  input  logic              i_ins_error,
  input  logic              i_dmem_error,
  input  logic              i_func_error,
  input  logic [3:0]        i_src_a,
  input  logic [3:0]        i_src_b,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b,
  output logic [2:0]        o_stat,
  output logic              o_halted,
  output logic [CNT_W-1:0]  o_retired
);

  typedef enum logic [2:0] {
    StAok = 3'd1,
    StHlt = 3'd2,
    StAdr = 3'd3,
    StIns = 3'd4
  } stat_e;

  localparam logic [3:0] RegNone = 4'hF;
  localparam logic [3:0] RegRsp  = 4'h4;

  stat_e             r_stat;
  stat_e             w_stat_nxt;
  logic [DATA_W-1:0] r_regs [15];
  logic [CNT_W-1:0]  r_retired;

  logic [3:0]        w_dst_e;
  logic [3:0]        w_dst_m;
  logic              w_active;
  logic              w_fault;
  logic              w_commit;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  always_comb begin
    w_dst_e = RegNone;
    w_dst_m = RegNone;
    case (i_icode)
      4'h2:                   w_dst_e = i_cnd ? i_rb : RegNone;
      4'h3, 4'h6:             w_dst_e = i_rb;
      4'h8, 4'h9, 4'hA, 4'hB: w_dst_e = RegRsp;
      default:                w_dst_e = RegNone;
    endcase
    if (i_icode == 4'h5 || i_icode == 4'hB) begin
      w_dst_m = i_ra;
    end
  end

  // Error inputs only matter once a valid instruction is seen while AOK.
  assign w_active = i_wb_valid && (r_stat == StAok);
  assign w_fault  = i_ins_error || i_func_error || i_dmem_error;
  assign w_commit = w_active && !w_fault;

  always_comb begin
    w_stat_nxt = r_stat;
    if (w_active) begin
      if (i_ins_error || i_func_error) begin
        w_stat_nxt = StIns;
      end else if (i_dmem_error) begin
        w_stat_nxt = StAdr;
      end else if (i_icode == 4'h0) begin
        w_stat_nxt = StHlt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= StAok;
    end else begin
      r_stat <= w_stat_nxt;
    end
  end

  // valM takes precedence when both ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) begin
        r_regs[i] <= (i == 4) ? RSP_INIT : '0;
      end
    end else if (w_commit) begin
      for (int unsigned i = 0; i < 15; i++) begin
        if (w_dst_m == 4'(i)) begin
          r_regs[i] <= i_val_m;
        end else if (w_dst_e == 4'(i)) begin
          r_regs[i] <= i_val_e;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (i_src_a == 4'(i)) w_rd_a = r_regs[i];
      if (i_src_b == 4'(i)) w_rd_b = r_regs[i];
    end
  end

  assign o_rd_a    = w_rd_a;
  assign o_rd_b    = w_rd_b;
  assign o_stat    = r_stat;
  assign o_halted  = (r_stat != StAok);
  assign o_retired = r_retired;

endmodule

// File: tb/tb_y86_writeback.sv
// Scoreboard bench for y86_writeback: a reference model of the register file and status
// queues expected observations after each step, which are then popped and compared.
module tb_y86_writeback;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_valid, cnd, ins_error, dmem_error, func_error;
  logic [3:0]    icode, ra, rb, src_a, src_b;
  logic [DW-1:0] val_e, val_m, rd_a, rd_b;
  logic [2:0]    stat;
  logic          halted;
  logic [CW-1:0] retired;

  y86_writeback #(.DATA_W(DW), .RSP_INIT(64'd1023), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wb_valid  (wb_valid),
    .i_icode     (icode),
    .i_ra        (ra),
    .i_rb        (rb),
    .i_cnd       (cnd),
    .i_val_e     (val_e),
    .i_val_m     (val_m),
    .i_ins_error (ins_error),
    .i_dmem_error(dmem_error),
    .i_func_error(func_error),
    .i_src_a     (src_a),
    .i_src_b     (src_b),
    .o_rd_a      (rd_a),
    .o_rd_b      (rd_b),
    .o_stat      (stat),
    .o_halted    (halted),
    .o_retired   (retired)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] m_regs [15];
  logic [2:0]    m_stat;
  logic [CW-1:0] m_ret;

  typedef struct {
    string         tag;
    int            kind;  // 0 stat, 1 halted, 2 retired, 3 rdA, 4 rdB
    logic [3:0]    src;
    logic [DW-1:0] exp;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] m_read(input logic [3:0] s);
    return (s == 4'hF) ? '0 : m_regs[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? 64'd1023 : '0;
    m_stat = 3'd1;
    m_ret  = '0;
  endtask

  task automatic push(input string tag, input int kind, input logic [3:0] s,
                      input logic [DW-1:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.src = s; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic push_state(input string tag);
    push({tag, "_stat"}, 0, 4'h0, 64'(m_stat));
    push({tag, "_halted"}, 1, 4'h0, 64'(m_stat != 3'd1));
    push({tag, "_retired"}, 2, 4'h0, 64'(m_ret));
  endtask

  task automatic push_reg(input string tag, input logic [3:0] s, input bit use_b);
    push(tag, use_b ? 4 : 3, s, m_read(s));
  endtask

  task automatic drain();
    exp_t e;
    logic [DW-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.kind == 3) src_a = e.src;
      if (e.kind == 4) src_b = e.src;
      #1;
      case (e.kind)
        0:       obs = 64'(stat);
        1:       obs = 64'(halted);
        2:       obs = 64'(retired);
        3:       obs = rd_a;
        default: obs = rd_b;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  // One instruction presented for a single cycle; the model applies the specified behaviour.
  task automatic exec(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                      input logic c, input logic [DW-1:0] ve, input logic [DW-1:0] vm,
                      input logic ie, input logic de, input logic fe);
    logic [3:0] de_idx, dm_idx;
    @(negedge clk);
    icode = ic; ra = a; rb = b; cnd = c; val_e = ve; val_m = vm;
    ins_error = ie; dmem_error = de; func_error = fe; wb_valid = 1'b1;
    src_a = b;
    #1 check("pre_edge_rd", rd_a, m_read(b));
    @(posedge clk);
    if (m_stat == 3'd1) begin
      if (ie || fe) m_stat = 3'd4;
      else if (de) m_stat = 3'd3;
      else begin
        if (ic == 4'h0) m_stat = 3'd2;
        m_ret++;
        de_idx = 4'hF;
        dm_idx = 4'hF;
        if (ic == 4'h2 && c) de_idx = b;
        if (ic == 4'h3 || ic == 4'h6) de_idx = b;
        if (ic >= 4'h8 && ic <= 4'hB) de_idx = 4'h4;
        if (ic == 4'h5 || ic == 4'hB) dm_idx = a;
        if (de_idx != 4'hF) m_regs[de_idx] = ve;
        if (dm_idx != 4'hF) m_regs[dm_idx] = vm;
      end
    end
    #1;
    wb_valid = 1'b0; ins_error = 1'b0; dmem_error = 1'b0; func_error = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] picks [5];
    logic [3:0] pk;
    picks[0] = 4'h2; picks[1] = 4'h3; picks[2] = 4'h6; picks[3] = 4'h8; picks[4] = 4'h5;
    rst_n = 1'b0; wb_valid = 1'b0; icode = 4'h1; ra = 4'hF; rb = 4'hF; cnd = 1'b0;
    val_e = '0; val_m = '0; ins_error = 1'b0; dmem_error = 1'b0; func_error = 1'b0;
    src_a = 4'h4; src_b = 4'h0;
    model_reset();
    #12 rst_n = 1'b1;

    push("reset_rsp", 3, 4'h4, 64'd1023);
    push("reset_r0", 4, 4'h0, 64'd0);
    push_state("reset");
    drain();

    exec(4'h3, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0, 1'b0, 1'b0, 1'b0);
    push("irmovq_r2", 3, 4'h2, 64'h55);
    push_state("irmovq");
    drain();

    exec(4'h2, 4'h1, 4'h3, 1'b0, 64'd7, 64'h0, 1'b0, 1'b0, 1'b0);
    push("cmov_nc_r3", 3, 4'h3, 64'd0);
    push_state("cmov_nc");
    drain();
    exec(4'h2, 4'h1, 4'h3, 1'b1, 64'd7, 64'h0, 1'b0, 1'b0, 1'b0);
    push("cmov_c_r3", 3, 4'h3, 64'd7);
    push_state("cmov_c");
    drain();

    exec(4'hB, 4'h4, 4'hF, 1'b0, 64'd1024, 64'h99, 1'b0, 1'b0, 1'b0);
    push("popq_rsp_m_wins", 3, 4'h4, 64'h99);
    drain();
    exec(4'hB, 4'h1, 4'hF, 1'b0, 64'd1024, 64'd5, 1'b0, 1'b0, 1'b0);
    push("popq_r1", 3, 4'h1, 64'd5);
    push("popq_rsp", 4, 4'h4, 64'd1024);
    push_state("popq");
    drain();

    for (int n = 0; n < 24; n++) begin
      pk = picks[$urandom_range(0, 4)];
      exec(pk, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) push_reg("rand_sweep", 4'(i), (i % 2) == 1);
    push_state("rand");
    drain();

    // Idle cycles with random error inputs must not disturb state.
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      ins_error = 1'($urandom); dmem_error = 1'($urandom); func_error = 1'($urandom);
      icode = 4'h3; rb = 4'h2; val_e = 64'hDEAD;
    end
    @(negedge clk);
    ins_error = 1'b0; dmem_error = 1'b0; func_error = 1'b0;
    push_reg("idle_r2", 4'h2, 1'b0);
    push_state("idle");
    drain();

    exec(4'h5, 4'h6, 4'hF, 1'b0, 64'h0, 64'hABCD, 1'b0, 1'b1, 1'b0);
    push_reg("adr_r6", 4'h6, 1'b0);
    push_state("adr");
    drain();
    exec(4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0);
    push_reg("adr_ignored_r7", 4'h7, 1'b0);
    push_state("adr_absorb");
    drain();

    // Asynchronous reset mid-cycle, observed before the next edge.
    @(posedge clk);
    src_a = 4'h4; src_b = 4'h1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_stat", 64'(stat), 64'd1);
    check("async_rst_halted", 64'(halted), 64'd0);
    check("async_rst_retired", 64'(retired), 64'd0);
    check("async_rst_rsp", rd_a, 64'd1023);
    check("async_rst_r1", rd_b, 64'd0);
    for (int i = 0; i < 16; i++) push_reg("rst_sweep", 4'(i), 1'b0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    exec(4'h3, 4'hF, 4'h8, 1'b0, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b0);
    exec(4'h5, 4'h9, 4'hF, 1'b0, 64'h0, 64'h1, 1'b0, 1'b1, 1'b1);
    push_reg("ins_r9", 4'h9, 1'b0);
    push_reg("ins_r8", 4'h8, 1'b1);
    push_state("ins_prio");
    drain();

    sync_reset();
    exec(4'h6, 4'hF, 4'hA, 1'b0, 64'h5, 64'h0, 1'b1, 1'b0, 1'b0);
    push_reg("ins_only_rA", 4'hA, 1'b0);
    push_state("ins_only");
    drain();

    sync_reset();
    exec(4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    push_state("halt");
    drain();
    exec(4'h3, 4'hF, 4'h5, 1'b0, 64'h42, 64'h0, 1'b0, 1'b0, 1'b0);
    push_reg("halt_ignored_r5", 4'h5, 1'b0);
    push_state("halt_absorb");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
